// File: rtl/output_mem_read_arbiter.sv
// output_mem_read_arbiter
// Shares the single read port of the output (partial-sum) memory between the
// partial-sum controller and the DMA readout engine. One read is accepted per
// cycle. An origin-tag FIFO (0 = psum, 1 = dma) tracks up to MAX_OUTSTANDING
// in-flight reads so that returning words are steered back, in order, to the
// requester that issued them.
//
// Build option: define OMEM_ARB_RR_EN for round-robin arbitration between the
// two requesters. Leave it undefined (default) for fixed priority, psum first.
module output_mem_read_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // partial-sum controller
    input  logic [ADDR_WIDTH-1:0] psum_radd,
    input  logic                  psum_rden,
    output logic                  psum_rrdy,
    output logic [DATA_WIDTH-1:0] psum_odat,
    output logic                  psum_ovld,
    // DMA readout engine
    input  logic [ADDR_WIDTH-1:0] dma_radd,
    input  logic                  dma_rden,
    output logic                  dma_rrdy,
    output logic [DATA_WIDTH-1:0] dma_odat,
    output logic                  dma_ovld,
    // output memory decoder, read side
    output logic [ADDR_WIDTH-1:0] mem_radd,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_odat,
    input  logic                  mem_ovld,
    // status
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  err_unexp
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        GNT_PSUM = 1'b0,
        GNT_DMA  = 1'b1
    } grant_e;

    // Tag FIFO storage and pointers; pointers wrap naturally (depth is 2^n).
    logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

    grant_e                     last_grant_q, last_grant_d;
    logic                       err_q, err_d;

    logic                       psum_ovld_q, psum_ovld_d;
    logic                       dma_ovld_q, dma_ovld_d;
    logic [DATA_WIDTH-1:0]      psum_odat_q, psum_odat_d;
    logic [DATA_WIDTH-1:0]      dma_odat_q, dma_odat_d;

    logic full;
    logic empty;
    logic psum_gnt;
    logic dma_gnt;
    logic push;
    logic pop;
    logic head_tag;

    // No same-cycle pop bypass: a full FIFO blocks both requesters even when
    // a response is returning in this cycle.
    assign full     = (cnt_q == CNT_WIDTH'(MAX_OUTSTANDING));
    assign empty    = (cnt_q == '0);
    assign push     = psum_gnt | dma_gnt;
    assign pop      = mem_ovld & ~empty;
    assign head_tag = tag_q[rd_ptr_q];

    // Combinational grant: at most one requester is accepted per cycle.
    always_comb begin
        psum_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (!full) begin
`ifdef OMEM_ARB_RR_EN
            if (psum_rden && dma_rden) begin
                // Contended: hand the port to whoever did not win last time.
                if (last_grant_q == GNT_PSUM) begin
                    dma_gnt = 1'b1;
                end else begin
                    psum_gnt = 1'b1;
                end
            end else begin
                psum_gnt = psum_rden;
                dma_gnt  = dma_rden;
            end
`else
            psum_gnt = psum_rden;
            dma_gnt  = dma_rden & ~psum_rden;
`endif
        end
    end

    // Zero-latency issue path to the memory decoder.
    always_comb begin
        mem_radd = '0;
        if (psum_gnt) begin
            mem_radd = psum_radd;
        end else if (dma_gnt) begin
            mem_radd = dma_radd;
        end
    end

    assign mem_rden  = push;
    assign psum_rrdy = psum_gnt;
    assign dma_rrdy  = dma_gnt;

    // Next-state: tag FIFO push/pop, in-flight count, grant history, response routing.
    always_comb begin
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        last_grant_d = last_grant_q;
        err_d        = err_q | (mem_ovld & empty);
        psum_ovld_d  = pop & ~head_tag;
        dma_ovld_d   = pop & head_tag;
        psum_odat_d  = psum_odat_q;
        dma_odat_d   = dma_odat_q;

        if (push) begin
            tag_d[wr_ptr_q] = dma_gnt;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            last_grant_d    = dma_gnt ? GNT_DMA : GNT_PSUM;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (head_tag) begin
                dma_odat_d = mem_odat;
            end else begin
                psum_odat_d = mem_odat;
            end
        end
    end

    // State register with synchronous active-low reset; last_grant resets to
    // dma so that psum wins the first contended grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            last_grant_q <= GNT_DMA;
            err_q        <= 1'b0;
            psum_ovld_q  <= 1'b0;
            dma_ovld_q   <= 1'b0;
            psum_odat_q  <= '0;
            dma_odat_q   <= '0;
        end else begin
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            psum_ovld_q  <= psum_ovld_d;
            dma_ovld_q   <= dma_ovld_d;
            psum_odat_q  <= psum_odat_d;
            dma_odat_q   <= dma_odat_d;
        end
    end

    assign psum_ovld   = psum_ovld_q;
    assign dma_ovld    = dma_ovld_q;
    assign psum_odat   = psum_odat_q;
    assign dma_odat    = dma_odat_q;
    assign outstanding = cnt_q;
    assign err_unexp   = err_q;

    // Invariants: the in-flight count never exceeds the FIFO depth, and
    // last_grant always records the requester accepted on the previous edge.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CNT_WIDTH'(MAX_OUTSTANDING));

    a_last_grant: assert property (@(posedge clk) disable iff (!rst_n)
        push |=> ((last_grant_q == GNT_DMA) == $past(dma_gnt)));

endmodule

// File: tb/tb_output_mem_read_arbiter.sv
module tb_output_mem_read_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] psum_radd, dma_radd, mem_radd;
    logic          psum_rden, dma_rden, mem_rden;
    logic          psum_rrdy, dma_rrdy;
    logic [DW-1:0] psum_odat, dma_odat, mem_odat;
    logic          psum_ovld, dma_ovld, mem_ovld;
    logic [CW-1:0] outstanding;
    logic          err_unexp;

    int checks = 0;
    int errors = 0;

    output_mem_read_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .psum_radd(psum_radd), .psum_rden(psum_rden), .psum_rrdy(psum_rrdy),
        .psum_odat(psum_odat), .psum_ovld(psum_ovld),
        .dma_radd(dma_radd), .dma_rden(dma_rden), .dma_rrdy(dma_rrdy),
        .dma_odat(dma_odat), .dma_ovld(dma_ovld),
        .mem_radd(mem_radd), .mem_rden(mem_rden),
        .mem_odat(mem_odat), .mem_ovld(mem_ovld),
        .outstanding(outstanding), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    // Step to 1 time unit after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        psum_rden = 1'b0; psum_radd = '0;
        dma_rden  = 1'b0; dma_radd  = '0;
        mem_ovld  = 1'b0; mem_odat  = '0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (psum_rrdy !== 1'b0) begin errors++; $display("FAIL reset_psum_rrdy got %0h exp 0", psum_rrdy); end
        checks++; if (dma_rrdy !== 1'b0) begin errors++; $display("FAIL reset_dma_rrdy got %0h exp 0", dma_rrdy); end
        checks++; if (mem_rden !== 1'b0) begin errors++; $display("FAIL reset_mem_rden got %0h exp 0", mem_rden); end
        checks++; if (mem_radd !== '0) begin errors++; $display("FAIL reset_mem_radd got %0h exp 0", mem_radd); end
        checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
        checks++; if (psum_ovld !== 1'b0 || dma_ovld !== 1'b0) begin errors++; $display("FAIL reset_ovld got %0h/%0h exp 0/0", psum_ovld, dma_ovld); end
        checks++; if (psum_odat !== '0 || dma_odat !== '0) begin errors++; $display("FAIL reset_odat got %0h/%0h exp 0/0", psum_odat, dma_odat); end
        checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", err_unexp); end
    endtask

    task automatic test_single_read();
        do_reset();
        tick(); psum_rden = 1'b1; psum_radd = 32'h10; #1;
        checks++; if (psum_rrdy !== 1'b1) begin errors++; $display("FAIL single_rrdy got %0h exp 1", psum_rrdy); end
        checks++; if (mem_rden !== 1'b1) begin errors++; $display("FAIL single_mem_rden got %0h exp 1", mem_rden); end
        checks++; if (mem_radd !== 32'h10) begin errors++; $display("FAIL single_mem_radd got %0h exp 10", mem_radd); end
        tick(); psum_rden = 1'b0; psum_radd = '0; #1;
        checks++; if (outstanding !== CW'(1)) begin errors++; $display("FAIL single_outstanding got %0d exp 1", outstanding); end
        checks++; if (psum_ovld !== 1'b0) begin errors++; $display("FAIL single_early_ovld1 got %0h exp 0", psum_ovld); end
        tick(); mem_ovld = 1'b1; mem_odat = 32'hCAFE0010; #1;
        checks++; if (psum_ovld !== 1'b0) begin errors++; $display("FAIL single_early_ovld2 got %0h exp 0", psum_ovld); end
        tick(); mem_ovld = 1'b0; mem_odat = '0; #1;
        checks++; if (psum_ovld !== 1'b1) begin errors++; $display("FAIL single_psum_ovld got %0h exp 1", psum_ovld); end
        checks++; if (psum_odat !== 32'hCAFE0010) begin errors++; $display("FAIL single_psum_odat got %0h exp cafe0010", psum_odat); end
        checks++; if (dma_ovld !== 1'b0) begin errors++; $display("FAIL single_dma_ovld got %0h exp 0", dma_ovld); end
        checks++; if (outstanding !== '0) begin errors++; $display("FAIL single_drained got %0d exp 0", outstanding); end
        tick(); #1;
        checks++; if (psum_ovld !== 1'b0 || psum_odat !== 32'hCAFE0010) begin errors++; $display("FAIL single_hold got ovld %0h dat %0h exp 0/cafe0010", psum_ovld, psum_odat); end
    endtask

    task automatic test_contention();
        int np = 0;
        int nd = 0;
        bit exp_p;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            psum_rden = 1'b1; psum_radd = 32'h100;
            dma_rden  = 1'b1; dma_radd  = 32'h200;
            mem_ovld  = (i > 0); mem_odat = DW'(i);
            #1;
`ifdef OMEM_ARB_RR_EN
            exp_p = ((i % 2) == 0);
`else
            exp_p = 1'b1;
`endif
            checks++; if (psum_rrdy !== exp_p || dma_rrdy !== !exp_p) begin errors++; $display("FAIL contention_grant cycle %0d got %0h/%0h exp %0h/%0h", i, psum_rrdy, dma_rrdy, exp_p, !exp_p); end
            checks++; if (mem_radd !== (exp_p ? 32'h100 : 32'h200)) begin errors++; $display("FAIL contention_radd cycle %0d got %0h", i, mem_radd); end
            np += int'(psum_rrdy);
            nd += int'(dma_rrdy);
        end
`ifdef OMEM_ARB_RR_EN
        checks++; if (np != 3 || nd != 3) begin errors++; $display("FAIL contention_counts got %0d/%0d exp 3/3", np, nd); end
`else
        checks++; if (np != 6 || nd != 0) begin errors++; $display("FAIL contention_counts got %0d/%0d exp 6/0", np, nd); end
`endif
    endtask

    task automatic test_full_stall();
        int acc = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(); psum_rden = 1'b1; psum_radd = 32'h40; dma_rden = 1'b1; dma_radd = 32'h80; #1;
            acc += int'(psum_rrdy) + int'(dma_rrdy);
        end
        checks++; if (acc != MAXO) begin errors++; $display("FAIL full_accepts got %0d exp %0d", acc, MAXO); end
        tick(); #1;
        checks++; if (psum_rrdy !== 1'b0 || dma_rrdy !== 1'b0) begin errors++; $display("FAIL full_rrdy got %0h/%0h exp 0/0", psum_rrdy, dma_rrdy); end
        checks++; if (outstanding !== CW'(MAXO)) begin errors++; $display("FAIL full_outstanding got %0d exp %0d", outstanding, MAXO); end
        tick(); mem_ovld = 1'b1; mem_odat = 32'h1234; #1;
        checks++; if (psum_rrdy !== 1'b0 || dma_rrdy !== 1'b0) begin errors++; $display("FAIL full_no_bypass got %0h/%0h exp 0/0", psum_rrdy, dma_rrdy); end
        tick(); mem_ovld = 1'b0; #1;
        checks++; if (outstanding !== CW'(MAXO - 1)) begin errors++; $display("FAIL full_after_pop got %0d exp %0d", outstanding, MAXO - 1); end
        checks++; if ((psum_rrdy | dma_rrdy) !== 1'b1) begin errors++; $display("FAIL full_reaccept got %0h/%0h exp one", psum_rrdy, dma_rrdy); end
        tick(); #1;
        checks++; if (outstanding !== CW'(MAXO) || psum_rrdy !== 1'b0 || dma_rrdy !== 1'b0) begin errors++; $display("FAIL full_refilled got cnt %0d rrdy %0h/%0h exp %0d 0/0", outstanding, psum_rrdy, dma_rrdy, MAXO); end
    endtask

    task automatic test_interleave();
        bit          origin [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] pq[$];
        logic [DW-1:0] dq[$];
        logic [DW-1:0] ep[$];
        logic [DW-1:0] ed[$];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(); idle_inputs();
            if (origin[i]) begin dma_rden = 1'b1; dma_radd = AW'(i); end
            else begin psum_rden = 1'b1; psum_radd = AW'(i); end
            #1;
            checks++; if ((origin[i] ? dma_rrdy : psum_rrdy) !== 1'b1) begin errors++; $display("FAIL interleave_issue %0d got %0h/%0h", i, psum_rrdy, dma_rrdy); end
            if (origin[i]) ed.push_back(DW'(32'hA + i)); else ep.push_back(DW'(32'hA + i));
        end
        for (int i = 0; i < 5; i++) begin
            tick(); idle_inputs();
            if (i < 4) begin mem_ovld = 1'b1; mem_odat = DW'(32'hA + i); end
            #1;
            if (psum_ovld === 1'b1) pq.push_back(psum_odat);
            if (dma_ovld === 1'b1) dq.push_back(dma_odat);
        end
        checks++; if (pq != ep) begin errors++; $display("FAIL interleave_psum got %p exp %p", pq, ep); end
        checks++; if (dq != ed) begin errors++; $display("FAIL interleave_dma got %p exp %p", dq, ed); end
    endtask

    task automatic test_push_pop();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick(); psum_rden = 1'b1; psum_radd = AW'(32'h300 + i); #1;
        end
        tick(); psum_rden = 1'b0; dma_rden = 1'b1; dma_radd = 32'h400; mem_ovld = 1'b1; mem_odat = 32'h5A5A; #1;
        checks++; if (outstanding !== CW'(2) || dma_rrdy !== 1'b1) begin errors++; $display("FAIL pushpop_pre got cnt %0d rrdy %0h exp 2/1", outstanding, dma_rrdy); end
        tick(); idle_inputs(); #1;
        checks++; if (outstanding !== CW'(2)) begin errors++; $display("FAIL pushpop_cnt got %0d exp 2", outstanding); end
        checks++; if (psum_ovld !== 1'b1 || psum_odat !== 32'h5A5A) begin errors++; $display("FAIL pushpop_route got %0h/%0h exp 1/5a5a", psum_ovld, psum_odat); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        tick(); psum_rden = 1'b1; psum_radd = 32'h1; #1;
        tick(); psum_radd = 32'h2; mem_ovld = 1'b1; mem_odat = 32'h77; #1;
        tick(); idle_inputs(); dma_rden = 1'b1; dma_radd = 32'h3; #1;
        tick(); idle_inputs(); psum_rden = 1'b1; psum_radd = 32'h4; #1;
        tick(); idle_inputs(); #1;
        checks++; if (outstanding !== CW'(3) || psum_odat !== 32'h77) begin errors++; $display("FAIL inflight_pre got cnt %0d dat %0h exp 3/77", outstanding, psum_odat); end
        do_reset();
        #1;
        checks++; if (outstanding !== '0 || err_unexp !== 1'b0 || psum_odat !== '0) begin errors++; $display("FAIL inflight_reset got cnt %0d err %0h dat %0h exp 0/0/0", outstanding, err_unexp, psum_odat); end
        for (int i = 0; i < 5; i++) begin
            tick(); idle_inputs();
            if (i < 3) begin mem_ovld = 1'b1; mem_odat = DW'(32'h55 + i); end
            #1;
            checks++; if (psum_ovld !== 1'b0 || dma_ovld !== 1'b0) begin errors++; $display("FAIL inflight_ovld %0d got %0h/%0h exp 0/0", i, psum_ovld, dma_ovld); end
            checks++; if (err_unexp !== (i >= 1)) begin errors++; $display("FAIL inflight_err %0d got %0h exp %0h", i, err_unexp, (i >= 1)); end
        end
    endtask

    // Random traffic against a queue-based reference model.
    task automatic test_random();
        bit            q[$];
        bit            lg_dma = 1'b1;
        bit            p_req = 1'b0, d_req = 1'b0;
        logic [AW-1:0] p_addr = '0, d_addr = '0;
        bit            exp_pv = 1'b0, exp_dv = 1'b0;
        logic [DW-1:0] exp_pd = '0, exp_dd = '0;
        bit            gp, gd, full, t;
        logic [AW-1:0] exp_radd;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!p_req && ($urandom_range(0, 2) != 0)) begin p_req = 1'b1; p_addr = AW'($urandom); end
            if (!d_req && ($urandom_range(0, 2) != 0)) begin d_req = 1'b1; d_addr = AW'($urandom); end
            psum_rden = p_req; psum_radd = p_addr;
            dma_rden  = d_req; dma_radd  = d_addr;
            mem_ovld  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            mem_odat  = DW'($urandom);
            #1;
            full = (q.size() == MAXO);
            gp = 1'b0; gd = 1'b0;
            if (!full) begin
`ifdef OMEM_ARB_RR_EN
                if (p_req && d_req) begin gd = !lg_dma; gp = lg_dma; end
                else begin gp = p_req; gd = d_req; end
`else
                gp = p_req; gd = d_req && !p_req;
`endif
            end
            exp_radd = gp ? p_addr : (gd ? d_addr : '0);
            checks++; if (psum_rrdy !== gp || dma_rrdy !== gd) begin errors++; $display("FAIL rand_grant c%0d got %0h/%0h exp %0h/%0h", c, psum_rrdy, dma_rrdy, gp, gd); end
            checks++; if (mem_rden !== (gp | gd) || mem_radd !== exp_radd) begin errors++; $display("FAIL rand_mem c%0d got %0h/%0h exp %0h/%0h", c, mem_rden, mem_radd, gp | gd, exp_radd); end
            checks++; if (outstanding !== CW'(q.size())) begin errors++; $display("FAIL rand_outstanding c%0d got %0d exp %0d", c, outstanding, q.size()); end
            checks++; if (psum_ovld !== exp_pv || psum_odat !== exp_pd) begin errors++; $display("FAIL rand_psum c%0d got %0h/%0h exp %0h/%0h", c, psum_ovld, psum_odat, exp_pv, exp_pd); end
            checks++; if (dma_ovld !== exp_dv || dma_odat !== exp_dd) begin errors++; $display("FAIL rand_dma c%0d got %0h/%0h exp %0h/%0h", c, dma_ovld, dma_odat, exp_dv, exp_dd); end
            checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rand_err c%0d got %0h exp 0", c, err_unexp); end
            exp_pv = 1'b0; exp_dv = 1'b0;
            if (mem_ovld) begin
                t = q.pop_front();
                if (t) begin exp_dv = 1'b1; exp_dd = mem_odat; end
                else begin exp_pv = 1'b1; exp_pd = mem_odat; end
            end
            if (gp) begin q.push_back(1'b0); lg_dma = 1'b0; p_req = 1'b0; end
            if (gd) begin q.push_back(1'b1); lg_dma = 1'b1; d_req = 1'b0; end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_full_stall();
        test_interleave();
        test_push_pop();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_mem_read_arbiter.md
# output_mem_read_arbiter

Shares the single read port of the output (partial-sum) memory between two requesters: the partial-sum controller (accumulate read-back) and the DMA readout engine (result drain to host). Sits between both requesters and the output memory address decoder's read side. Accepts one read per cycle and tracks up to `MAX_OUTSTANDING` in-flight reads in an origin-tag FIFO, so each returning word is steered to the requester that issued it, in order.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, read address width (all ports)
- `DATA_WIDTH`, 32, read data width
- `MAX_OUTSTANDING`, 4, tag FIFO depth; power of two, 2..16
- `CNT_WIDTH`, 3, width of outstanding counter; must hold `MAX_OUTSTANDING`

Ports:
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `psum_radd` in `ADDR_WIDTH` — partial-sum controller read address
- `psum_rden` in 1 — partial-sum read request
- `psum_rrdy` out 1 — request accepted this cycle
- `psum_odat` out `DATA_WIDTH` — returned data
- `psum_ovld` out 1 — `psum_odat` valid
- `dma_radd`, `dma_rden`, `dma_rrdy`, `dma_odat`, `dma_ovld` — same as above for the DMA requester
- `mem_radd` out `ADDR_WIDTH` — to the decoder read address
- `mem_rden` out 1 — to the decoder read enable
- `mem_odat` in `DATA_WIDTH` — memory read data
- `mem_ovld` in 1 — memory read data valid
- `outstanding` out `CNT_WIDTH` — current in-flight read count
- `err_unexp` out 1 — sticky: `mem_ovld` arrived with no read outstanding

## Operation
- Requester holds `*_radd` stable with `*_rden` high until `*_rrdy`; a read is accepted in the cycle where `*_rden && *_rrdy`.
- `full` = (`outstanding == MAX_OUTSTANDING`). When `full`, both `*_rrdy` are 0; there is no same-cycle pop bypass.
- Grant is combinational:
  - At most one `*_rrdy` is high per cycle.
  - `mem_rden = psum_rrdy | dma_rrdy`.
  - `mem_radd` = granted address; otherwise 0.
- On accept, push a tag (0 = psum, 1 = dma) into the tag FIFO.
- On `mem_ovld`, pop the head tag and route `mem_odat` to the tagged requester.
- Simultaneous push and pop: `outstanding` is unchanged and FIFO order is preserved.
- `mem_ovld` with an empty FIFO:
  - Data is dropped and no `*_ovld` is asserted.
  - `err_unexp` is set and stays set until reset.
- Grant policy depends on `OMEM_ARB_RR_EN` (see Configuration).
- `last_grant` register updates on every accept to the requester just accepted.
- Reset, including mid-operation:
  - Tag FIFO emptied; `outstanding` = 0; `last_grant` = dma, so psum wins the first contended grant.
  - All `*_ovld` = 0, all `*_odat` = 0, `err_unexp` = 0.
  - Responses still in flight that return after reset flag `err_unexp`.

## Timing
- Request to memory issue: 0 cycles (combinational pass-through).
- `mem_ovld` to `psum_ovld`/`dma_ovld`: 1 cycle (registered).
  - `*_odat` is registered alongside and holds its value when `*_ovld` = 0.
- Throughput: one accept per cycle while not `full`. Total added latency is 1 cycle plus the memory latency.
- `outstanding` and `err_unexp` are registered; both update one cycle after the triggering event.

## Configuration
- `OMEM_ARB_RR_EN` defined (round robin):
  - Both requesting: grant goes to the requester not equal to `last_grant`.
  - One requesting: that requester wins.
- Not defined (fixed priority):
  - psum always wins.
  - dma is granted only in cycles with `psum_rden` = 0.
  - `last_grant` is still maintained, but is unused.

## Test plan
- Reset, then psum read addr 0x10 with memory latency 2 → `mem_rden` same cycle, `psum_ovld` 3 cycles after accept with the memory data; `dma_ovld` stays 0.
- Both requesters hold `rden` for 6 cycles, RR build → grants alternate psum, dma, psum, dma…; fixed build → 6 psum grants and 0 dma.
- Memory stalls `mem_ovld` with `MAX_OUTSTANDING`=4 → exactly 4 accepts, then both `rrdy` = 0 and `outstanding`=4. One `mem_ovld` → exactly one further accept, in the cycle after `outstanding` drops to 3.
- Interleaved issue psum, dma, dma, psum with returns 0xA, 0xB, 0xC, 0xD → psum gets 0xA, 0xD; dma gets 0xB, 0xC, in order.
- Accept and `mem_ovld` in the same cycle at `outstanding`=2 → `outstanding` stays 2.
- Assert `rst_n`=0 with 3 reads in flight, release, then 3 `mem_ovld` pulses → no `*_ovld`; `err_unexp`=1 one cycle after the first pulse and held.
